urv_regfile_mp: RTL and testbench

URV_REGFILE_MP -- requirements
Module: urv_regfile_mp

---
 rtl/urv_regfile_mp_pkg.sv | 22 ++
 rtl/urv_regmem_p.sv | 39 +++
 rtl/urv_regfile_mp.sv | 162 ++++++++++++++++
 tb/tb_urv_regfile_mp.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/urv_regfile_mp_pkg.sv
// ============================================================================
// Module      : urv_regfile_mp_pkg
// Description : Shared defaults and clear-FSM state encoding for the
//               multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package urv_regfile_mp_pkg;

    localparam int C_DATA_W = 32;
    localparam int C_ADDR_W = 5;
    localparam int C_N_RD   = 2;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_t;

endpackage : urv_regfile_mp_pkg

`default_nettype wire

// File: rtl/urv_regmem_p.sv
// ============================================================================
// Module      : urv_regmem_p
// Description : One-read / one-write memory bank with a registered read port.
//               A same-edge read and write to one address returns old data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module urv_regmem_p
    import urv_regfile_mp_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int ADDR_W = C_ADDR_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule : urv_regmem_p

`default_nettype wire

// File: rtl/urv_regfile_mp.sv
// ============================================================================
// Module      : urv_regfile_mp
// Description : Multi-read-port register file with hardware clear after reset,
//               writeback (W) and execute (X) bypass. Optional per-entry
//               even parity when URV_REGFILE_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module urv_regfile_mp
    import urv_regfile_mp_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int ADDR_W = C_ADDR_W,
    parameter int N_RD   = C_N_RD
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     d_stall_i,
    input  logic [N_RD*ADDR_W-1:0]   rf_rs_i,
    input  logic [N_RD*ADDR_W-1:0]   d_rs_i,
    output logic [N_RD*DATA_W-1:0]   x_rs_value_o,
    input  logic [ADDR_W-1:0]        w_rd_i,
    input  logic [DATA_W-1:0]        w_rd_value_i,
    input  logic                     w_rd_store_i,
    input  logic                     w_bypass_rd_write_i,
    input  logic [DATA_W-1:0]        w_bypass_rd_value_i,
    output logic                     ready_o,
    output logic                     parity_err_o
);

    localparam int DEPTH = 2**ADDR_W;
`ifdef URV_REGFILE_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    rf_state_t         r_state;
    rf_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              w_ready;
    logic              w_clearing;
    logic              w_write;

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata_d;
    logic [MEM_W-1:0]  w_mem_wdata;

    logic [N_RD-1:0]   r_wbyp;
    logic [N_RD-1:0]   w_wbyp_nxt;
    logic [DATA_W-1:0] r_wbyp_data;
    logic [N_RD-1:0]   w_perr;

    assign w_ready    = (r_state == ST_RUN);
    assign w_clearing = (r_state == ST_CLEAR);
    assign w_write    = w_ready & ~d_stall_i & w_rd_store_i & (w_rd_i != '0);

    // Clear FSM: walk every address once, then hand the file to the pipeline
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clearing) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    assign w_mem_we      = w_clearing | w_write;
    assign w_mem_waddr   = w_clearing ? r_clr_cnt : w_rd_i;
    assign w_mem_wdata_d = w_clearing ? '0 : w_rd_value_i;
`ifdef URV_REGFILE_PARITY_EN
    assign w_mem_wdata   = {^w_mem_wdata_d, w_mem_wdata_d};
`else
    assign w_mem_wdata   = w_mem_wdata_d;
`endif

    // W-bypass state freezes on stall so a held fetch address keeps its forward
    always_ff @(posedge clk_i) begin
        if (rst_i || w_clearing) begin
            r_wbyp <= '0;
        end else if (!d_stall_i) begin
            r_wbyp <= w_wbyp_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_write) begin
            r_wbyp_data <= w_rd_value_i;
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_port
        logic [ADDR_W-1:0] w_rs;
        logic [ADDR_W-1:0] w_d_rs;
        logic [ADDR_W-1:0] r_rs_q;
        logic [MEM_W-1:0]  w_rdata;
        logic              w_xbyp;
        logic [DATA_W-1:0] w_val;

        assign w_rs          = rf_rs_i[k*ADDR_W +: ADDR_W];
        assign w_d_rs        = d_rs_i[k*ADDR_W +: ADDR_W];
        assign w_xbyp        = w_bypass_rd_write_i & (w_rd_i == w_d_rs) & (w_rd_i != '0);
        assign w_wbyp_nxt[k] = w_write & (w_rs == w_rd_i);

        always_ff @(posedge clk_i) begin
            r_rs_q <= w_rs;
        end

        urv_regmem_p #(
            .DATA_W (MEM_W),
            .ADDR_W (ADDR_W)
        ) u_mem (
            .clk     (clk_i),
            .i_raddr (w_rs),
            .o_rdata (w_rdata),
            .i_we    (w_mem_we),
            .i_waddr (w_mem_waddr),
            .i_wdata (w_mem_wdata)
        );

        always_comb begin
            w_val = '0;
            if (!w_ready) begin
                w_val = '0;
            end else if (w_xbyp) begin
                w_val = w_bypass_rd_value_i;
            end else if (r_wbyp[k]) begin
                w_val = r_wbyp_data;
            end else if (r_rs_q != '0) begin
                w_val = w_rdata[DATA_W-1:0];
            end
        end

        assign x_rs_value_o[k*DATA_W +: DATA_W] = w_val;

`ifdef URV_REGFILE_PARITY_EN
        assign w_perr[k] = w_ready & ~w_xbyp & ~r_wbyp[k] & (r_rs_q != '0) & (^w_rdata);
`else
        assign w_perr[k] = 1'b0;
`endif
    end

    assign ready_o      = w_ready;
    assign parity_err_o = |w_perr;

endmodule : urv_regfile_mp

`default_nettype wire

// File: tb/tb_urv_regfile_mp.sv
// ============================================================================
// Module      : tb_urv_regfile_mp
// Description : Self-checking bench for urv_regfile_mp against an architectural
//               register model (URV_REGFILE_PARITY_EN adds a parity-flip step).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_urv_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 2**AW;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               d_stall_i;
    logic [NR*AW-1:0]   rf_rs_i;
    logic [NR*AW-1:0]   d_rs_i;
    logic [NR*DW-1:0]   x_rs_value_o;
    logic [AW-1:0]      w_rd_i;
    logic [DW-1:0]      w_rd_value_i;
    logic               w_rd_store_i;
    logic               w_bypass_rd_write_i;
    logic [DW-1:0]      w_bypass_rd_value_i;
    logic               ready_o;
    logic               parity_err_o;

    urv_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .d_stall_i           (d_stall_i),
        .rf_rs_i             (rf_rs_i),
        .d_rs_i              (d_rs_i),
        .x_rs_value_o        (x_rs_value_o),
        .w_rd_i              (w_rd_i),
        .w_rd_value_i        (w_rd_value_i),
        .w_rd_store_i        (w_rd_store_i),
        .w_bypass_rd_write_i (w_bypass_rd_write_i),
        .w_bypass_rd_value_i (w_bypass_rd_value_i),
        .ready_o             (ready_o),
        .parity_err_o        (parity_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Architectural model: register contents plus the value each port fetched
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_rd  [NR];
    int            m_left;
    bit            m_ready;
    bit            m_perr;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        d_stall_i           = 1'b0;
        rf_rs_i             = '0;
        d_rs_i              = '0;
        w_rd_i              = '0;
        w_rd_value_i        = '0;
        w_rd_store_i        = 1'b0;
        w_bypass_rd_write_i = 1'b0;
        w_bypass_rd_value_i = '0;
    endtask

    // Inputs are already applied (low clock phase): check, clock, update model
    task automatic cycle();
        logic [DW-1:0] exp;
        logic [AW-1:0] drs;
        #1;
        check("ready", {31'd0, ready_o}, {31'd0, m_ready});
        for (int k = 0; k < NR; k++) begin
            drs = d_rs_i[k*AW +: AW];
            if (!m_ready)
                exp = '0;
            else if (w_bypass_rd_write_i && w_rd_i != '0 && w_rd_i == drs)
                exp = w_bypass_rd_value_i;
            else
                exp = m_rd[k];
            check($sformatf("port%0d", k), x_rs_value_o[k*DW +: DW], exp);
        end
        check("parity_err", {31'd0, parity_err_o}, {31'd0, m_perr});
        @(posedge clk_i);
        if (rst_i) begin
            m_left  = DEPTH;
            m_ready = 1'b0;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
            end
        end else if (!d_stall_i && w_rd_store_i && w_rd_i != '0) begin
            m_mem[w_rd_i] = w_rd_value_i;
        end
        for (int k = 0; k < NR; k++) m_rd[k] = m_mem[rf_rs_i[k*AW +: AW]];
        @(negedge clk_i);
    endtask

    initial begin
        logic [AW-1:0] a0;
        for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
        for (int k = 0; k < NR; k++) m_rd[k] = '0;
        m_perr  = 1'b0;
        m_ready = 1'b0;
        m_left  = DEPTH;
        set_idle();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);

        // Clear phase: ready low for DEPTH samples, high after
        rst_i = 1'b0;
        repeat (DEPTH + 1) cycle();

        // Every entry reads zero after clear
        for (int a = 0; a < DEPTH; a++) begin
            rf_rs_i = {AW'(DEPTH - 1 - a), AW'(a)};
            cycle();
        end
        set_idle();
        cycle();

        // x5 written, read on port 1 two cycles later
        w_rd_store_i = 1'b1; w_rd_i = 5'd5; w_rd_value_i = 32'hDEADBEEF;
        cycle();
        set_idle();
        rf_rs_i = {5'd5, 5'd0};
        cycle();
        cycle();

        // x7 written while port 0 fetches x7 in the same cycle
        w_rd_store_i = 1'b1; w_rd_i = 5'd7; w_rd_value_i = 32'h11;
        rf_rs_i = {5'd0, 5'd7};
        cycle();
        set_idle();
        rf_rs_i = {5'd0, 5'd7};
        cycle();

        // X-bypass wins over a pending W-bypass on port 1
        w_rd_store_i = 1'b1; w_rd_i = 5'd3; w_rd_value_i = 32'h55;
        rf_rs_i = {5'd3, 5'd0};
        cycle();
        w_rd_store_i = 1'b0;
        w_bypass_rd_write_i = 1'b1; w_rd_i = 5'd3;
        w_bypass_rd_value_i = 32'hA5A5A5A5;
        d_rs_i = {5'd3, 5'd0};
        cycle();
        set_idle();
        rf_rs_i = {5'd3, 5'd0};
        cycle();

        // x0 write ignored; stalled write to x4 dropped
        w_rd_store_i = 1'b1; w_rd_i = 5'd4; w_rd_value_i = 32'h33;
        cycle();
        w_rd_i = 5'd0; w_rd_value_i = 32'hFFFFFFFF;
        cycle();
        d_stall_i = 1'b1; w_rd_i = 5'd4; w_rd_value_i = 32'h22;
        cycle();
        cycle();
        set_idle();
        rf_rs_i = {5'd4, 5'd0};
        cycle();
        cycle();

        // Randomized traffic; fetch addresses held while stalled
        for (int i = 0; i < 400; i++) begin
            d_stall_i = ($urandom_range(0, 3) == 0);
            if (!d_stall_i) rf_rs_i = NR*AW'($urandom);
            w_rd_store_i        = ($urandom_range(0, 2) != 0);
            w_rd_i              = AW'($urandom);
            w_rd_value_i        = $urandom;
            w_bypass_rd_write_i = ($urandom_range(0, 3) == 0);
            w_bypass_rd_value_i = $urandom;
            for (int k = 0; k < NR; k++) begin
                a0 = ($urandom_range(0, 1) == 0) ? w_rd_i : AW'($urandom);
                d_rs_i[k*AW +: AW] = a0;
            end
            cycle();
        end
        set_idle();
        cycle();

`ifdef URV_REGFILE_PARITY_EN
        // Corrupt the stored parity of x9 in bank 0, then fetch it
        w_rd_store_i = 1'b1; w_rd_i = 5'd9; w_rd_value_i = 32'h1234;
        cycle();
        set_idle();
        cycle();
        dut.g_port[0].u_mem.r_mem[9][DW] = ~dut.g_port[0].u_mem.r_mem[9][DW];
        rf_rs_i = {5'd0, 5'd9};
        cycle();
        set_idle();
        m_perr = 1'b1;
        cycle();
        m_perr = 1'b0;
        cycle();
`endif

        // Reset issued mid-clear restarts the walk from address 0
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        repeat (10) cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        repeat (DEPTH + 1) cycle();
        rf_rs_i = {5'd5, 5'd7};
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_urv_regfile_mp

`default_nettype wire
